// File: rtl/mips_pkg.sv
// Shared constants and controller state type for the MIPS register-file access path.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StRdIssue,
    StRdCapture,
    StRspHold
  } state_e;

endpackage

// File: rtl/mips_wb_fifo.sv
// Writeback FIFO of {reg, data} pairs; every slot's register index and live flag are
// exported so the controller can detect read-after-write hazards.
module mips_wb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 32,
  parameter int unsigned AddrW = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic [AddrW-1:0]            push_reg_i,
  input  logic [DataW-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [AddrW-1:0]            head_reg_o,
  output logic [DataW-1:0]            head_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(Depth):0]      count_o,
  output logic [Depth-1:0][AddrW-1:0] entry_reg_o,
  output logic [Depth-1:0]            entry_vld_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Depth-1:0][AddrW-1:0] reg_q;
  logic [Depth-1:0][DataW-1:0] data_q;
  logic [PtrW:0]               wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]               rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]             wr_idx, rd_idx;
  logic                        do_push, do_pop;

  assign wr_idx  = wr_ptr_q[PtrW-1:0];
  assign rd_idx  = rd_ptr_q[PtrW-1:0];
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == CntW'(Depth));
  assign empty_o = (count_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_reg_o  = reg_q[rd_idx];
  assign head_data_o = data_q[rd_idx];
  assign entry_reg_o = reg_q;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    entry_vld_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      entry_vld_o[i] = ({1'b0, PtrW'(PtrW'(i) - rd_idx)} < count_o);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      reg_q[wr_idx]  <= push_reg_i;
      data_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/mips_reg_access_ctrl.sv
// Serializes operand reads and buffered writebacks onto a register file that cannot
// read and write in the same cycle, preserving RAW order and $0 semantics.
module mips_reg_access_ctrl #(
  parameter int unsigned WB_DEPTH = 4,
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  input  logic [ADDR_W-1:0]          rd_req_rs,
  input  logic [ADDR_W-1:0]          rd_req_rt,
  output logic                       rd_rsp_valid,
  input  logic                       rd_rsp_ready,
  output logic [DATA_W-1:0]          rd_rsp_data_1,
  output logic [DATA_W-1:0]          rd_rsp_data_2,
  input  logic                       wr_req_valid,
  output logic                       wr_req_ready,
  input  logic [ADDR_W-1:0]          wr_req_reg,
  input  logic [DATA_W-1:0]          wr_req_data,
  output logic [ADDR_W-1:0]          read_reg_1,
  output logic [ADDR_W-1:0]          read_reg_2,
  output logic [ADDR_W-1:0]          write_reg,
  output logic [DATA_W-1:0]          write_data,
  output logic                       signal_reg_write,
  input  logic [DATA_W-1:0]          read_data_1,
  input  logic [DATA_W-1:0]          read_data_2,
  output logic [$clog2(WB_DEPTH):0]  wb_count
);

  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(ZERO_REG);

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              rs_q, rs_d, rt_q, rt_d;
  logic [DATA_W-1:0]              rsp_1_q, rsp_1_d, rsp_2_q, rsp_2_d;
  logic                           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]              head_reg;
  logic [DATA_W-1:0]              head_data;
  logic [WB_DEPTH-1:0][ADDR_W-1:0] entry_reg;
  logic [WB_DEPTH-1:0]            entry_vld;
  logic                           hazard;

  mips_wb_fifo #(
    .Depth (WB_DEPTH),
    .DataW (DATA_W),
    .AddrW (ADDR_W)
  ) u_wb_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_reg_i  (wr_req_reg),
    .push_data_i (wr_req_data),
    .pop_i       (fifo_pop),
    .head_reg_o  (head_reg),
    .head_data_o (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (wb_count),
    .entry_reg_o (entry_reg),
    .entry_vld_o (entry_vld)
  );

  // Writes to $0 are acknowledged but never reach the register file.
  assign wr_req_ready = !fifo_full;
  assign fifo_push    = wr_req_valid && !fifo_full && (wr_req_reg != ZeroIdx);
  assign fifo_pop     = !fifo_empty && (state_q != StRdIssue);

  assign signal_reg_write = fifo_pop;
  assign write_reg        = fifo_pop ? head_reg : '0;
  assign write_data       = fifo_pop ? head_data : '0;

  assign rd_rsp_data_1 = rsp_1_q;
  assign rd_rsp_data_2 = rsp_2_q;

  // Only entries already buffered are compared; a same-cycle push is the caller's to order.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (entry_vld[i] &&
          (((rd_req_rs != ZeroIdx) && (entry_reg[i] == rd_req_rs)) ||
           ((rd_req_rt != ZeroIdx) && (entry_reg[i] == rd_req_rt)))) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rsp_1_d      = rsp_1_q;
    rsp_2_d      = rsp_2_q;
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    read_reg_1   = '0;
    read_reg_2   = '0;
    unique case (state_q)
      StIdle: begin
        rd_req_ready = 1'b1;
        if (rd_req_valid) begin
          rs_d    = rd_req_rs;
          rt_d    = rd_req_rt;
          state_d = hazard ? StDrain : StRdIssue;
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StRdIssue;
      end
      StRdIssue: begin
        read_reg_1 = rs_q;
        read_reg_2 = rt_q;
        state_d    = StRdCapture;
      end
      StRdCapture: begin
        rsp_1_d = (rs_q == ZeroIdx) ? '0 : read_data_1;
        rsp_2_d = (rt_q == ZeroIdx) ? '0 : read_data_2;
        state_d = StRspHold;
      end
      StRspHold: begin
        rd_rsp_valid = 1'b1;
        if (rd_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rs_q    <= '0;
      rt_q    <= '0;
      rsp_1_q <= '0;
      rsp_2_q <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rsp_1_q <= rsp_1_d;
      rsp_2_q <= rsp_2_d;
    end
  end

endmodule

// File: tb/tb_mips_reg_access_ctrl.sv
// Bench for mips_reg_access_ctrl: behavioural register file, architectural register model
// and an in-order writeback scoreboard, driven by directed and randomized traffic.
module tb_mips_reg_access_ctrl;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready;
  logic [4:0]  rd_req_rs, rd_req_rt;
  logic [31:0] rd_rsp_data_1, rd_rsp_data_2;
  logic        wr_req_valid, wr_req_ready;
  logic [4:0]  wr_req_reg;
  logic [31:0] wr_req_data;
  logic [4:0]  read_reg_1, read_reg_2, write_reg;
  logic [31:0] write_data, read_data_1, read_data_2;
  logic        signal_reg_write;
  logic [2:0]  wb_count;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_wr_pulses = 0;
  logic [31:0] arch [32];
  logic [31:0] rf [32];
  logic        rf_seeded = 1'b0;
  wb_t         sb [$];

  always #5 clk = ~clk;

  mips_reg_access_ctrl #(
    .WB_DEPTH (DEPTH),
    .DATA_W   (32),
    .ADDR_W   (5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rd_req_valid     (rd_req_valid),
    .rd_req_ready     (rd_req_ready),
    .rd_req_rs        (rd_req_rs),
    .rd_req_rt        (rd_req_rt),
    .rd_rsp_valid     (rd_rsp_valid),
    .rd_rsp_ready     (rd_rsp_ready),
    .rd_rsp_data_1    (rd_rsp_data_1),
    .rd_rsp_data_2    (rd_rsp_data_2),
    .wr_req_valid     (wr_req_valid),
    .wr_req_ready     (wr_req_ready),
    .wr_req_reg       (wr_req_reg),
    .wr_req_data      (wr_req_data),
    .read_reg_1       (read_reg_1),
    .read_reg_2       (read_reg_2),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .signal_reg_write (signal_reg_write),
    .read_data_1      (read_data_1),
    .read_data_2      (read_data_2),
    .wb_count         (wb_count)
  );

  function automatic logic [31:0] seed_val(int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  // Register file: reads are suppressed (outputs held) in any cycle that writes.
  always @(posedge clk) begin
    if (!rf_seeded) begin
      for (int i = 0; i < 32; i++) rf[i] <= seed_val(i);
      rf[0] <= 32'hBAD0_BAD0;
      rf_seeded <= 1'b1;
    end else if (signal_reg_write) begin
      if (write_reg != 5'd0) rf[write_reg] <= write_data;
    end else begin
      read_data_1 <= rf[read_reg_1];
      read_data_2 <= rf[read_reg_2];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_fail++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: occupancy, ready, and in-order writeback against the scoreboard.
  initial begin
    for (int i = 0; i < 32; i++) arch[i] = seed_val(i);
    arch[0] = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
      end else begin
        check("wb_count", 32'(wb_count), 32'(sb.size()));
        check("wr_req_ready", 32'(wr_req_ready), 32'(sb.size() != DEPTH));
        if (signal_reg_write) begin
          n_wr_pulses++;
          check("write_pending", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            wb_t e;
            e = sb.pop_front();
            check("write_reg", 32'(write_reg), 32'(e.r));
            check("write_data", write_data, e.d);
          end
        end
        if (wr_req_valid && wr_req_ready && (wr_req_reg != 5'd0)) begin
          sb.push_back('{r: wr_req_reg, d: wr_req_data});
          arch[wr_req_reg] = wr_req_data;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [4:0] r, input logic [31:0] d);
    int w;
    wr_req_reg   = r;
    wr_req_data  = d;
    wr_req_valid = 1'b1;
    w = 0;
    while (!wr_req_ready && w < 50) begin
      tick();
      w++;
    end
    if (!wr_req_ready) timeout("wr_req_ready_wait");
    tick();
    wr_req_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int w;
    w = 0;
    while (wb_count != 3'd0 && w < 50) begin
      tick();
      w++;
    end
    if (wb_count != 3'd0) timeout("drain_wait");
  endtask

  task automatic do_read(input logic [4:0] rs, input logic [4:0] rt, input int hold,
                         input int burst, output logic [31:0] d1, output logic [31:0] d2,
                         output int lat);
    logic [31:0] e1, e2;
    logic        no_pending;
    int          w;
    d1 = '0;
    d2 = '0;
    rd_req_rs    = rs;
    rd_req_rt    = rt;
    rd_req_valid = 1'b1;
    w = 0;
    while (!rd_req_ready && w < 50) begin
      tick();
      w++;
    end
    if (!rd_req_ready) begin
      timeout("rd_req_ready_wait");
      rd_req_valid = 1'b0;
      lat = 0;
      return;
    end
    e1 = (rs == 5'd0) ? 32'd0 : arch[rs];
    e2 = (rt == 5'd0) ? 32'd0 : arch[rt];
    no_pending = (wb_count == 3'd0);
    tick();
    rd_req_valid = 1'b0;
    lat = 1;
    while (!rd_rsp_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!rd_rsp_valid) begin
      timeout("rd_rsp_valid_wait");
      return;
    end
    if (no_pending) check("rd_latency", 32'(lat), 32'd3);
    d1 = rd_rsp_data_1;
    d2 = rd_rsp_data_2;
    check("rsp_data_1", d1, e1);
    check("rsp_data_2", d2, e2);
    check("rd_req_ready_busy", 32'(rd_req_ready), 32'd0);
    for (int k = 0; k < burst; k++) do_write(5'(10 + k), 32'hC0DE_0000 + 32'(k));
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", 32'(rd_rsp_valid), 32'd1);
      check("hold_data_1", rd_rsp_data_1, d1);
      check("hold_data_2", rd_rsp_data_2, d2);
      check("hold_req_ready", 32'(rd_req_ready), 32'd0);
    end
    rd_rsp_ready = 1'b1;
    tick();
    rd_rsp_ready = 1'b0;
    check("idle_after_rsp", 32'(rd_req_ready), 32'd1);
    check("valid_after_rsp", 32'(rd_rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] d1, d2;
    int          lat, p0;

    reset        = 1'b1;
    rd_req_valid = 1'b0;
    rd_req_rs    = '0;
    rd_req_rt    = '0;
    rd_rsp_ready = 1'b0;
    wr_req_valid = 1'b0;
    wr_req_reg   = '0;
    wr_req_data  = '0;
    repeat (3) tick();

    check("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("rst_rsp_data_1", rd_rsp_data_1, 32'd0);
    check("rst_rsp_data_2", rd_rsp_data_2, 32'd0);
    check("rst_reg_write", 32'(signal_reg_write), 32'd0);
    check("rst_read_reg_1", 32'(read_reg_1), 32'd0);
    check("rst_read_reg_2", 32'(read_reg_2), 32'd0);
    check("rst_write_reg", 32'(write_reg), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_wb_count", 32'(wb_count), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_req_ready", 32'(rd_req_ready), 32'd1);

    // Preload then plain read.
    do_write(5'd8, 32'h11);
    do_write(5'd9, 32'h22);
    wait_drained();
    do_read(5'd8, 5'd9, 0, 0, d1, d2, lat);
    check("t1_data_1", d1, 32'h11);
    check("t1_data_2", d2, 32'h22);
    check("t1_latency", 32'(lat), 32'd3);

    // RAW hazard: write then read the same register immediately.
    p0 = n_wr_pulses;
    do_write(5'd5, 32'hDEAD);
    do_read(5'd5, 5'd0, 0, 0, d1, d2, lat);
    check("t2_data_1", d1, 32'hDEAD);
    check("t2_data_2", d2, 32'd0);
    check("t2_drain_latency", 32'(lat), 32'd4);
    check("t2_write_pulses", 32'(n_wr_pulses - p0), 32'd1);

    // Five writebacks pushed while the response is held.
    p0 = n_wr_pulses;
    do_read(5'd8, 5'd9, 2, 5, d1, d2, lat);
    wait_drained();
    check("t3_write_pulses", 32'(n_wr_pulses - p0), 32'd5);
    do_read(5'd10, 5'd14, 0, 0, d1, d2, lat);
    check("t3_first", d1, 32'hC0DE_0000);
    check("t3_last", d2, 32'hC0DE_0004);

    // Writes to $0 are dropped; reads of $0 return zero.
    p0 = n_wr_pulses;
    do_write(5'd0, 32'hFFFF);
    repeat (3) tick();
    check("t4_no_pulse", 32'(n_wr_pulses - p0), 32'd0);
    do_read(5'd0, 5'd0, 0, 0, d1, d2, lat);
    check("t4_data_1", d1, 32'd0);
    check("t4_data_2", d2, 32'd0);

    // Long backpressure on the response.
    do_read(5'd3, 5'd4, 10, 0, d1, d2, lat);
    check("t5_data_1", d1, seed_val(3));

    // Randomized write bursts followed by reads over a small register window.
    for (int it = 0; it < 40; it++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        logic [4:0] r;
        r = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
        do_write(r, $urandom);
        if ($urandom_range(0, 2) == 0) tick();
      end
      do_read(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 3), 0,
              d1, d2, lat);
    end

    // Reset during capture with two writebacks queued.
    wait_drained();
    check("t6_idle", 32'(rd_req_ready), 32'd1);
    rd_req_rs    = 5'd1;
    rd_req_rt    = 5'd2;
    rd_req_valid = 1'b1;
    wr_req_reg   = 5'd20;
    wr_req_data  = 32'h2020_2020;
    wr_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    wr_req_reg   = 5'd21;
    wr_req_data  = 32'h2121_2121;
    tick();
    wr_req_valid = 1'b0;
    check("t6_pre_count", 32'(wb_count), 32'd2);
    check("t6_pre_write", 32'(signal_reg_write), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("t6_wb_count", 32'(wb_count), 32'd0);
    check("t6_reg_write", 32'(signal_reg_write), 32'd0);
    check("t6_req_ready", 32'(rd_req_ready), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_reg_access_ctrl.md
Name: mips_reg_access_ctrl

Overview:
- Initiator-side controller for the MIPS register file (read_reg_1/2, write_reg, write_data, signal_reg_write in; registered read_data_1/2 out).
- Accepts operand-read requests and writeback requests from the datapath, each over a valid/ready handshake.
- Buffers writebacks in a small FIFO and serializes access, because the register file suppresses reads in any cycle that writes.
- Enforces RAW ordering and the hard-wired-zero semantics of $0.

Parameters:
- WB_DEPTH, 4, writeback FIFO entries; must be a power of 2, and at least 2.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.

Ports:
- clk  in  1  rising-edge clock, single domain.
- reset  in  1  synchronous, active-high reset.
- rd_req_valid  in  1  operand-read request valid.
- rd_req_ready  out  1  controller can accept a read.
- rd_req_rs  in  ADDR_W  first source register.
- rd_req_rt  in  ADDR_W  second source register.
- rd_rsp_valid  out  1  operand response valid.
- rd_rsp_ready  in  1  consumer accepts the response.
- rd_rsp_data_1  out  DATA_W  value of rs.
- rd_rsp_data_2  out  DATA_W  value of rt.
- wr_req_valid  in  1  writeback request valid.
- wr_req_ready  out  1  writeback FIFO not full.
- wr_req_reg  in  ADDR_W  destination register.
- wr_req_data  in  DATA_W  writeback value.
- read_reg_1  out  ADDR_W  to register file.
- read_reg_2  out  ADDR_W  to register file.
- write_reg  out  ADDR_W  to register file.
- write_data  out  DATA_W  to register file.
- signal_reg_write  out  1  register-file write enable.
- read_data_1  in  DATA_W  from register file; valid the cycle after the read is issued.
- read_data_2  in  DATA_W  from register file; valid the cycle after the read is issued.
- wb_count  out  log2(WB_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset:
  - state=IDLE and FIFO empty.
  - rd_rsp_valid=0 and rd_rsp_data_1/2=0.
  - signal_reg_write=0; all register-file address and data outputs 0.
  - wb_count=0.
  - Reset mid-operation abandons any read in flight and discards buffered writes.
  - Register-file contents are not reset.
- FSM states: IDLE, DRAIN, RD_ISSUE, RD_CAPTURE, RSP_HOLD.
- IDLE:
  - rd_req_ready=1; on a read handshake, rs/rt are latched.
  - If any FIFO entry's register equals a nonzero rs or rt, go to DRAIN; otherwise go to RD_ISSUE.
- DRAIN: stays until the FIFO is empty, then goes to RD_ISSUE.
- RD_ISSUE:
  - read_reg_1/2 = latched rs/rt and signal_reg_write forced 0 (no drain in this cycle).
  - Always goes to RD_CAPTURE.
- RD_CAPTURE:
  - Samples read_data_1/2 into the response registers.
  - A source index of 0 returns 0 regardless of register-file content.
  - Goes to RSP_HOLD.
- RSP_HOLD:
  - rd_rsp_valid=1; data is held stable until rd_rsp_ready.
  - On handshake, go to IDLE.
  - rd_req_ready=0 in every state except IDLE.
- Read latency, no hazard:
  - Request handshake at edge 0, issue in cycle 1, capture in cycle 2.
  - rd_rsp_valid=1 in cycle 3.
- Writeback path:
  - wr_req_ready = !full; it is based on occupancy only, with no same-cycle pop bypass.
  - A handshake with wr_req_reg=0 is accepted and dropped (not pushed).
- Drain:
  - In every state except RD_ISSUE, a non-empty FIFO pops its head, driving write_reg/write_data and signal_reg_write=1 for that cycle. This gives 1 write per cycle, in FIFO order.
  - A drain in RD_CAPTURE is legal because the register file holds read_data during writes.
- Simultaneous push and pop: both happen and wb_count is unchanged.
- Pointers wrap modulo WB_DEPTH, with an extra pointer bit to distinguish full from empty.
- A write pushed in the same cycle as a read request's hazard check is not considered for that request; the caller orders the writeback first.

Decomposition:
- Shared package mips_pkg:
  - DATA_W and ADDR_W constants.
  - State enum and ZERO_REG constant.
- One natural sub-module: mips_wb_fifo. It is a synchronous FIFO holding {reg, data}, with push/pop/full/empty/count, and exposes all entry registers for the hazard compare.

Test Plan:
- After reset, preload reg 8=0x11, reg 9=0x22 via writes; read rs=8, rt=9 -> rd_rsp_valid in cycle 3 after the handshake, data 0x11/0x22.
- Push write reg 5=0xDEAD, then immediately read rs=5 -> DRAIN entered, signal_reg_write pulses once, response 0xDEAD (not the stale value).
- Push 5 writes with WB_DEPTH=4 while the controller is held in RSP_HOLD -> drains proceed, wb_count never exceeds 4, wr_req_ready=0 only when count=4, all 5 values land in order.
- Write reg 0=0xFFFF, then read rs=0, rt=0 -> signal_reg_write never asserted for reg 0; response 0/0.
- Hold rd_rsp_ready=0 for 10 cycles -> response data stable and rd_req_ready=0; release -> IDLE the next cycle.
- Assert reset during RD_CAPTURE with 2 queued writes -> next cycle rd_rsp_valid=0, wb_count=0, signal_reg_write=0.
